mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 35 +++
 rtl/mem_access_if.sv | 21 ++
 rtl/mem_access_load_align.sv | 33 +++
 rtl/mem_access.sv | 129 ++++++++++++
 tb/tb_mem_access.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage: memory-op encodings, bus size codes and FSM states.
package mem_access_pkg;

  typedef enum logic [3:0] {
    MemNone = 4'd0,
    MemLb   = 4'd1,
    MemLbu  = 4'd2,
    MemLh   = 4'd3,
    MemLhu  = 4'd4,
    MemLw   = 4'd5,
    MemSb   = 4'd6,
    MemSh   = 4'd7,
    MemSw   = 4'd8
  } mem_op_e;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAddr,
    StWaitData,
    StDone
  } state_e;

  function automatic logic [1:0] op_size(mem_op_e op);
    case (op)
      MemLb, MemLbu, MemSb: op_size = SizeByte;
      MemLh, MemLhu, MemSh: op_size = SizeHalf;
      default:              op_size = SizeWord;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// SRAM-like data bus between the memory stage (master) and the data memory (slave).
interface mem_access_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it per load op.
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  mem_op_e     op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (op_i)
      MemLb:   data_o = {{24{byte_lane[7]}}, byte_lane};
      MemLbu:  data_o = {24'd0, byte_lane};
      MemLh:   data_o = {{16{half_lane[15]}}, half_lane};
      MemLhu:  data_o = {16'd0, half_lane};
      MemLw:   data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores on the SRAM-like bus, aligns load data and
// holds the pipeline via o_stallreq until the response arrives.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_d1,
  input  logic [31:0] i_d2,
  input  logic [3:0]  i_mem_op,
  input  logic [4:0]  i_rn,
  input  logic        i_write_regfile,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic        i_write_hilo,
  input  logic        i_stall,
  output logic [31:0] o_d1,
  output logic [31:0] o_d2,
  output logic [4:0]  o_rn,
  output logic        o_write_regfile,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_write_hilo,
  output logic        o_mem_to_regfile,
  output logic        o_addr_err,
  output logic        o_stallreq,
  mem_access_if.master data_if
);

  mem_op_e     op;
  logic        is_load, is_store, misaligned, issue;
  logic [1:0]  size;
  logic [31:0] aligned;
  logic [31:0] wdata;

  state_e      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic        req, stallreq;
  logic [31:0] d2;

  assign op = mem_op_e'(i_mem_op);

  always_comb begin
    is_load  = (op == MemLb) || (op == MemLbu) || (op == MemLh) || (op == MemLhu) ||
               (op == MemLw);
    is_store = (op == MemSb) || (op == MemSh) || (op == MemSw);
    size     = op_size(op);
    misaligned = (is_load || is_store) &&
                 (((size == SizeHalf) && i_d1[0]) || ((size == SizeWord) && (i_d1[1:0] != 2'd0)));
    issue    = (is_load || is_store) && !misaligned;
    case (size)
      SizeByte: wdata = {4{i_d2[7:0]}};
      SizeHalf: wdata = {2{i_d2[15:0]}};
      default:  wdata = i_d2;
    endcase
  end

  mem_access_load_align u_load_align (
    .rdata_i (data_if.data_rdata),
    .addr_i  (i_d1[1:0]),
    .op_i    (op),
    .data_o  (aligned)
  );

  // ex_mem is frozen while o_stallreq is high, so request fields come straight from the inputs.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    req      = 1'b0;
    stallreq = 1'b0;
    d2       = '0;
    unique case (state_q)
      StIdle: begin
        req      = issue;
        stallreq = issue;
        if (issue) state_d = data_if.data_addr_ok ? StWaitData : StWaitAddr;
      end
      StWaitAddr: begin
        req      = 1'b1;
        stallreq = 1'b1;
        if (data_if.data_addr_ok) state_d = StWaitData;
      end
      StWaitData: begin
        if (data_if.data_data_ok) begin
          d2      = aligned;
          buf_d   = aligned;
          state_d = i_stall ? StDone : StIdle;
        end else begin
          stallreq = 1'b1;
        end
      end
      StDone: begin
        d2 = buf_q;
        if (!i_stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (reset) begin
      state_d  = StIdle;
      buf_d    = '0;
      req      = 1'b0;
      stallreq = 1'b0;
      d2       = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    buf_q   <= buf_d;
  end

  assign data_if.data_req   = req;
  assign data_if.data_wr    = !reset && is_store;
  assign data_if.data_size  = reset ? 2'd0 : size;
  assign data_if.data_addr  = reset ? '0 : i_d1;
  assign data_if.data_wdata = reset ? '0 : wdata;

  assign o_d1             = reset ? '0 : i_d1;
  assign o_d2             = d2;
  assign o_rn             = reset ? '0 : i_rn;
  assign o_hi             = reset ? '0 : i_hi;
  assign o_lo             = reset ? '0 : i_lo;
  assign o_write_hilo     = !reset && i_write_hilo;
  assign o_addr_err       = !reset && misaligned;
  assign o_write_regfile  = !reset && i_write_regfile && !misaligned;
  assign o_mem_to_regfile = !reset && is_load;
  assign o_stallreq       = stallreq;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vectors plus randomized loads/stores checked
// against an arithmetic reference model of lane selection, extension and byte replication.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_d1, i_d2, i_hi, i_lo;
  logic [3:0]  i_mem_op;
  logic [4:0]  i_rn;
  logic        i_write_regfile, i_write_hilo, i_stall;
  logic [31:0] o_d1, o_d2, o_hi, o_lo;
  logic [4:0]  o_rn;
  logic        o_write_regfile, o_write_hilo, o_mem_to_regfile, o_addr_err, o_stallreq;

  int checks = 0;
  int errors = 0;

  mem_access_if bus ();

  mem_access dut (
    .clk              (clk),
    .reset            (reset),
    .i_d1             (i_d1),
    .i_d2             (i_d2),
    .i_mem_op         (i_mem_op),
    .i_rn             (i_rn),
    .i_write_regfile  (i_write_regfile),
    .i_hi             (i_hi),
    .i_lo             (i_lo),
    .i_write_hilo     (i_write_hilo),
    .i_stall          (i_stall),
    .o_d1             (o_d1),
    .o_d2             (o_d2),
    .o_rn             (o_rn),
    .o_write_regfile  (o_write_regfile),
    .o_hi             (o_hi),
    .o_lo             (o_lo),
    .o_write_hilo     (o_write_hilo),
    .o_mem_to_regfile (o_mem_to_regfile),
    .o_addr_err       (o_addr_err),
    .o_stallreq       (o_stallreq),
    .data_if          (bus)
  );

  always #5 clk = ~clk;

  // Reference model
  function automatic logic [31:0] exp_load(mem_op_e op, logic [31:0] addr, logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> ((addr % 4) * 8)) & 32'hFF;
    h = (rdata >> (((addr / 2) % 2) * 16)) & 32'hFFFF;
    case (op)
      MemLb:   return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      MemLbu:  return b;
      MemLh:   return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      MemLhu:  return h;
      MemLw:   return rdata;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(mem_op_e op, logic [31:0] rt);
    case (op)
      MemSb:   return (rt & 32'hFF) * 32'h0101_0101;
      MemSh:   return (rt & 32'hFFFF) * 32'h0001_0001;
      default: return rt;
    endcase
  endfunction

  function automatic int exp_size(mem_op_e op);
    if (op == MemLb || op == MemLbu || op == MemSb) return 0;
    if (op == MemLh || op == MemLhu || op == MemSh) return 1;
    return 2;
  endfunction

  function automatic bit op_is_load(mem_op_e op);
    return op == MemLb || op == MemLbu || op == MemLh || op == MemLhu || op == MemLw;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    i_mem_op = MemNone;
    i_stall = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata = $urandom;
  endtask

  // One complete transaction with addr_ok after addr_wait extra cycles, data_ok after data_wait
  // extra cycles, and i_stall held for stall_cycles cycles starting with the data_ok cycle.
  task automatic run_op(string tag, mem_op_e op, logic [31:0] addr, logic [31:0] rt,
                        logic [31:0] rdata, int addr_wait, int data_wait, int stall_cycles);
    logic [31:0] exp_d2;
    logic        wr_rf;
    logic [4:0]  rn;
    exp_d2 = exp_load(op, addr, rdata);
    wr_rf = 1'($urandom);
    rn = 5'($urandom);
    i_mem_op = op; i_d1 = addr; i_d2 = rt; i_write_regfile = wr_rf; i_rn = rn;
    i_stall = 1'b0; bus.data_data_ok = 1'b0; bus.data_addr_ok = (addr_wait == 0);
    for (int k = 0; k <= addr_wait; k++) begin
      if (k > 0) begin
        cyc();
        bus.data_addr_ok = (k == addr_wait);
      end
      #1;
      checks++;
      if (bus.data_req !== 1'b1 || o_stallreq !== 1'b1) begin
        errors++;
        $display("FAIL %s req_phase[%0d]: req=%0b stallreq=%0b want 1/1", tag, k,
                 bus.data_req, o_stallreq);
      end
      checks++;
      if (bus.data_addr !== addr || bus.data_size !== 2'(exp_size(op)) ||
          bus.data_wr !== !op_is_load(op)) begin
        errors++;
        $display("FAIL %s req_fields[%0d]: addr=%h size=%0d wr=%0b want %h/%0d/%0b", tag, k,
                 bus.data_addr, bus.data_size, bus.data_wr, addr, exp_size(op), !op_is_load(op));
      end
      if (!op_is_load(op)) begin
        checks++;
        if (bus.data_wdata !== exp_wdata(op, rt)) begin
          errors++;
          $display("FAIL %s wdata[%0d]: got %h want %h", tag, k, bus.data_wdata,
                   exp_wdata(op, rt));
        end
      end
    end
    checks++;
    if (o_write_regfile !== wr_rf || o_rn !== rn || o_mem_to_regfile !== op_is_load(op) ||
        o_addr_err !== 1'b0) begin
      errors++;
      $display("FAIL %s passthru: wrf=%0b rn=%0d m2r=%0b aerr=%0b want %0b/%0d/%0b/0", tag,
               o_write_regfile, o_rn, o_mem_to_regfile, o_addr_err, wr_rf, rn, op_is_load(op));
    end
    cyc();
    bus.data_addr_ok = 1'b0;
    for (int k = 0; k < data_wait; k++) begin
      #1;
      checks++;
      if (bus.data_req !== 1'b0 || o_stallreq !== 1'b1) begin
        errors++;
        $display("FAIL %s wait_data[%0d]: req=%0b stallreq=%0b want 0/1", tag, k,
                 bus.data_req, o_stallreq);
      end
      cyc();
    end
    bus.data_data_ok = 1'b1; bus.data_rdata = rdata; i_stall = (stall_cycles > 0);
    #1;
    checks++;
    if (o_d2 !== exp_d2 || bus.data_req !== 1'b0 || o_stallreq !== 1'b0) begin
      errors++;
      $display("FAIL %s data_ok: d2=%h req=%0b stallreq=%0b want %h/0/0", tag, o_d2,
               bus.data_req, o_stallreq, exp_d2);
    end
    cyc();
    bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
    for (int s = 0; s < stall_cycles; s++) begin
      i_stall = (s < stall_cycles - 1);
      #1;
      checks++;
      if (o_d2 !== exp_d2 || bus.data_req !== 1'b0 || o_stallreq !== 1'b0) begin
        errors++;
        $display("FAIL %s done_hold[%0d]: d2=%h req=%0b stallreq=%0b want %h/0/0", tag, s, o_d2,
                 bus.data_req, o_stallreq, exp_d2);
      end
      cyc();
    end
    drive_idle();
    #1;
    checks++;
    if (bus.data_req !== 1'b0 || o_stallreq !== 1'b0 || o_d2 !== 32'd0) begin
      errors++;
      $display("FAIL %s back_idle: req=%0b stallreq=%0b d2=%h want 0/0/0", tag, bus.data_req,
               o_stallreq, o_d2);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_mem_op = MemLw; i_d1 = 32'h0000_1000; i_d2 = $urandom; i_rn = 5'd7;
    i_write_regfile = 1'b1; i_hi = $urandom; i_lo = $urandom; i_write_hilo = 1'b1;
    i_stall = 1'b0; bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = $urandom;
    cyc();
    cyc();
    checks++;
    if (bus.data_req !== 1'b0 || o_stallreq !== 1'b0 || o_d2 !== 32'd0 || o_d1 !== 32'd0 ||
        o_write_regfile !== 1'b0 || o_hi !== 32'd0 || o_mem_to_regfile !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: req=%0b stall=%0b d2=%h d1=%h wrf=%0b hi=%h m2r=%0b want 0s",
               bus.data_req, o_stallreq, o_d2, o_d1, o_write_regfile, o_hi, o_mem_to_regfile);
    end
    drive_idle();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 8; i++) begin
      drive_idle();
      i_d1 = $urandom; i_d2 = $urandom; i_rn = 5'($urandom); i_hi = $urandom; i_lo = $urandom;
      i_write_regfile = 1'($urandom); i_write_hilo = 1'($urandom);
      bus.data_addr_ok = 1'($urandom); bus.data_data_ok = 1'($urandom);
      #1;
      checks++;
      if (o_d1 !== i_d1 || o_rn !== i_rn || o_hi !== i_hi || o_lo !== i_lo ||
          o_write_regfile !== i_write_regfile || o_write_hilo !== i_write_hilo) begin
        errors++;
        $display("FAIL none_passthru[%0d]: d1=%h rn=%0d hi=%h lo=%h wrf=%0b whl=%0b", i, o_d1,
                 o_rn, o_hi, o_lo, o_write_regfile, o_write_hilo);
      end
      checks++;
      if (bus.data_req !== 1'b0 || o_stallreq !== 1'b0 || o_d2 !== 32'd0 ||
          o_mem_to_regfile !== 1'b0 || o_addr_err !== 1'b0) begin
        errors++;
        $display("FAIL none_idle[%0d]: req=%0b stall=%0b d2=%h m2r=%0b aerr=%0b want 0s", i,
                 bus.data_req, o_stallreq, o_d2, o_mem_to_regfile, o_addr_err);
      end
      cyc();
    end
    drive_idle();
  endtask

  task automatic test_directed();
    run_op("lw_basic", MemLw, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 0, 0, 0);
    cyc();
    run_op("lb_sign", MemLb, 32'h0000_1003, 32'd0, 32'h80FF_FF7F, 0, 0, 0);
    cyc();
    run_op("lbu_zero", MemLbu, 32'h0000_1003, 32'd0, 32'h80FF_FF7F, 0, 0, 0);
    cyc();
    run_op("sh_delay", MemSh, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 3, 0, 0);
    cyc();
    run_op("lw_stall", MemLw, 32'h0000_1000, 32'd0, 32'hCAFE_F00D, 0, 1, 2);
    cyc();
    // Spot-check the model itself against the hand-derived values.
    checks++;
    if (exp_load(MemLb, 32'h1003, 32'h80FF_FF7F) !== 32'hFFFF_FF80 ||
        exp_wdata(MemSh, 32'h1234_ABCD) !== 32'hABCD_ABCD) begin
      errors++;
      $display("FAIL model_vectors: lb=%h sh=%h", exp_load(MemLb, 32'h1003, 32'h80FF_FF7F),
               exp_wdata(MemSh, 32'h1234_ABCD));
    end
  endtask

  task automatic test_misaligned();
    mem_op_e ops[5] = '{MemLh, MemLhu, MemSh, MemLw, MemSw};
    for (int i = 0; i < 10; i++) begin
      mem_op_e op;
      logic [31:0] addr;
      op = ops[i % 5];
      addr = $urandom;
      if (exp_size(op) == 1) addr[0] = 1'b1;
      else if (addr[1:0] == 2'd0) addr[1:0] = 2'($urandom_range(1, 3));
      if (i == 0) begin
        op = MemLw;
        addr = 32'h0000_1002;
      end
      drive_idle();
      i_mem_op = op; i_d1 = addr; i_write_regfile = 1'b1; bus.data_addr_ok = 1'b1;
      #1;
      checks++;
      if (o_addr_err !== 1'b1 || bus.data_req !== 1'b0 || o_write_regfile !== 1'b0 ||
          o_stallreq !== 1'b0) begin
        errors++;
        $display("FAIL misalign[%0d] op=%0d addr=%h: aerr=%0b req=%0b wrf=%0b stall=%0b", i, op,
                 addr, o_addr_err, bus.data_req, o_write_regfile, o_stallreq);
      end
      cyc();
    end
    drive_idle();
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    i_mem_op = MemLw; i_d1 = 32'h0000_1000; bus.data_addr_ok = 1'b1;
    cyc();
    bus.data_addr_ok = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.data_req !== 1'b0 || o_stallreq !== 1'b0 || o_d2 !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_assert: req=%0b stall=%0b d2=%h want 0/0/0", bus.data_req,
               o_stallreq, o_d2);
    end
    cyc();
    reset = 1'b0;
    i_mem_op = MemNone; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1357_9BDF;
    #1;
    checks++;
    if (o_d2 !== 32'd0 || bus.data_req !== 1'b0 || o_stallreq !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop: d2=%h req=%0b stall=%0b want 0/0/0", o_d2, bus.data_req,
               o_stallreq);
    end
    cyc();
    // A stray data_ok alongside a fresh request in IDLE must be ignored.
    i_mem_op = MemLw; i_d1 = 32'h0000_1004; bus.data_addr_ok = 1'b0;
    #1;
    checks++;
    if (bus.data_req !== 1'b1 || o_stallreq !== 1'b1 || o_d2 !== 32'd0) begin
      errors++;
      $display("FAIL stray_ok_idle: req=%0b stall=%0b d2=%h want 1/1/0", bus.data_req,
               o_stallreq, o_d2);
    end
    cyc();
    bus.data_addr_ok = 1'b1;
    #1;
    checks++;
    if (bus.data_req !== 1'b1 || o_stallreq !== 1'b1 || o_d2 !== 32'd0) begin
      errors++;
      $display("FAIL stray_ok_waddr: req=%0b stall=%0b d2=%h want 1/1/0", bus.data_req,
               o_stallreq, o_d2);
    end
    cyc();
    rd = $urandom;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = rd;
    #1;
    checks++;
    if (o_d2 !== rd || o_stallreq !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: d2=%h stall=%0b want %h/0", o_d2, o_stallreq, rd);
    end
    cyc();
    drive_idle();
    cyc();
  endtask

  task automatic test_random_ops();
    mem_op_e ops[8] = '{MemLb, MemLbu, MemLh, MemLhu, MemLw, MemSb, MemSh, MemSw};
    for (int i = 0; i < 40; i++) begin
      mem_op_e op;
      logic [31:0] addr;
      op = ops[$urandom_range(0, 7)];
      addr = $urandom;
      if (exp_size(op) == 1) addr[0] = 1'b0;
      if (exp_size(op) == 2) addr[1:0] = 2'd0;
      run_op("random", op, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
             $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) cyc();
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_directed();
    test_misaligned();
    test_reset_mid();
    test_random_ops();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
